// File: rtl/fetch_unit.sv
// Instruction-fetch stage: loads the reset vector, then assembles 1- or 2-halfword
// instructions from an async-read halfword memory for the IF/ID buffer.
module fetch_unit #(
    parameter int PC_W           = 32,
    parameter int RESET_VEC_ADDR = 0,
    parameter int LONG_BIT       = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            IF_Stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [31:0]     fetch_instruction,
    output logic [PC_W-1:0] fetch_pc,
    output logic [PC_W-1:0] fetch_next_pc,
    output logic            fetch_valid
);

    // state  | meaning
    // VEC_HI | reading upper half of reset vector
    // VEC_LO | reading lower half of reset vector
    // FIRST  | first halfword of an instruction at pc
    // SECOND | immediate halfword of a long instruction at pc+1
    typedef enum logic [1:0] {VEC_HI, VEC_LO, FIRST, SECOND} state_t;

    localparam logic [PC_W-1:0] VEC_HI_ADDR = PC_W'(RESET_VEC_ADDR);
    localparam logic [PC_W-1:0] VEC_LO_ADDR = PC_W'(RESET_VEC_ADDR + 1);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [15:0]     hold, hold_nxt;
    logic            fetching;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= VEC_HI;
            pc    <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            hold  <= hold_nxt;
        end
    end

    assign fetching = (state == FIRST) || (state == SECOND);

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        hold_nxt          = hold;
        imem_addr         = pc;
        fetch_valid       = 1'b0;
        fetch_instruction = '0;
        fetch_pc          = '0;
        fetch_next_pc     = '0;

        case (state)
            VEC_HI: begin
                imem_addr             = VEC_HI_ADDR;
                pc_nxt[PC_W-1:16]     = imem_data[PC_W-17:0];
                state_nxt             = VEC_LO;
            end
            VEC_LO: begin
                imem_addr   = VEC_LO_ADDR;
                pc_nxt[15:0] = imem_data;
                state_nxt   = FIRST;
            end
            FIRST: begin
                imem_addr = pc;
                if (!imem_data[LONG_BIT]) begin
                    fetch_valid       = 1'b1;
                    fetch_instruction = {imem_data, 16'h0000};
                    fetch_pc          = pc;
                    fetch_next_pc     = pc + PC_W'(1);
                    pc_nxt            = pc + PC_W'(1);
                end else begin
                    hold_nxt  = imem_data;
                    state_nxt = SECOND;
                end
            end
            default: begin
                imem_addr         = pc + PC_W'(1);
                fetch_valid       = 1'b1;
                fetch_instruction = {hold, imem_data};
                fetch_pc          = pc;
                fetch_next_pc     = pc + PC_W'(2);
                pc_nxt            = pc + PC_W'(2);
                state_nxt         = FIRST;
            end
        endcase

        // Branch wins over stall; any half-built long instruction is dropped.
        if (fetching && branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = FIRST;
            hold_nxt  = hold;
        end else if (fetching && IF_Stall) begin
            pc_nxt    = pc;
            state_nxt = state;
            hold_nxt  = hold;
        end

        // Present a clean bubble while reset is asserted, before state is known.
        if (!rst_n) begin
            fetch_valid       = 1'b0;
            fetch_instruction = '0;
            fetch_pc          = '0;
            fetch_next_pc     = '0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset vector, short/long streams, stall,
// branch-over-stall, PC wrap and mid-run reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IF_Stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_next_pc;
    logic        fetch_valid;

    logic [15:0] mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[9:0]];

    fetch_unit #(.PC_W(32), .RESET_VEC_ADDR(0), .LONG_BIT(0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .IF_Stall          (IF_Stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .fetch_next_pc     (fetch_next_pc),
        .fetch_valid       (fetch_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_out(input string tag, input logic [31:0] addr, input logic valid,
                             input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] npc);
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".valid"}, {31'b0, fetch_valid}, {31'b0, valid});
        check({tag, ".instr"}, fetch_instruction, instr);
        check({tag, ".pc"},    fetch_pc, pc);
        check({tag, ".npc"},   fetch_next_pc, npc);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0000; mem[1] = 16'h0100;
        mem[10'h100] = 16'h1000; mem[10'h101] = 16'h2000; mem[10'h102] = 16'h3000;
        rst_n = 1'b0; IF_Stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // Reset and vector load, then short stream
        repeat (2) next_cyc();
        check("rst.valid", {31'b0, fetch_valid}, 32'd0);
        check("rst.instr", fetch_instruction, 32'd0);
        check("rst.pc",    fetch_pc, 32'd0);
        rst_n = 1'b1;
        check_out("vec_hi", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        check_out("vec_lo", 32'h1, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        check_out("short0", 32'h100, 1'b1, 32'h1000_0000, 32'h100, 32'h101);
        next_cyc();
        check_out("short1", 32'h101, 1'b1, 32'h2000_0000, 32'h101, 32'h102);
        next_cyc();
        check_out("short2", 32'h102, 1'b1, 32'h3000_0000, 32'h102, 32'h103);

        // Long instruction with stall in SECOND
        mem[10'h100] = 16'h4001; mem[10'h101] = 16'hBEEF; mem[10'h102] = 16'h5000;
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        next_cyc();
        check_out("long.bub", 32'h100, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        check_out("long", 32'h101, 1'b1, 32'h4001_BEEF, 32'h100, 32'h102);
        IF_Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            check_out("stall", 32'h101, 1'b1, 32'h4001_BEEF, 32'h100, 32'h102);
        end
        IF_Stall = 1'b0;
        next_cyc();
        check_out("post_stall", 32'h102, 1'b1, 32'h5000_0000, 32'h102, 32'h103);

        // Branch back into the long instruction, then branch out of SECOND under stall
        branch_taken = 1'b1; branch_target = 32'h100;
        next_cyc();
        branch_taken = 1'b0;
        check_out("br.bub", 32'h100, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        check_out("br.second", 32'h101, 1'b1, 32'h4001_BEEF, 32'h100, 32'h102);
        mem[10'h200] = 16'h6000;
        branch_taken = 1'b1; branch_target = 32'h200; IF_Stall = 1'b1;
        next_cyc();
        branch_taken = 1'b0; IF_Stall = 1'b0;
        check_out("br_stall", 32'h200, 1'b1, 32'h6000_0000, 32'h200, 32'h201);

        // Long instruction straddling the PC wrap
        mem[10'h3FF] = 16'h7001; mem[0] = 16'h1234;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        next_cyc();
        branch_taken = 1'b0;
        check_out("wrap.bub", 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        check_out("wrap", 32'h0, 1'b1, 32'h7001_1234, 32'hFFFF_FFFF, 32'h1);
        next_cyc();
        check_out("wrap.next", 32'h1, 1'b1, 32'h0100_0000, 32'h1, 32'h2);

        // Mid-run reset; branch during vector load is ignored
        mem[0] = 16'h0000;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", {31'b0, fetch_valid}, 32'd0);
        next_cyc();
        rst_n = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
        check_out("midrst.hi", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        check_out("midrst.lo", 32'h1, 1'b0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        branch_taken = 1'b0;
        check_out("midrst.first", 32'h100, 1'b0, 32'h0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
